// File: rtl/sram_responder_if.sv
// ------------------------------------------------------------------
// sram_responder_if: mem_in/mem_out request/response bundle, rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface sram_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_fault;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready, mem_fault
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready, mem_fault
  );
endinterface

`default_nettype wire

// File: rtl/sram_responder.sv
// ------------------------------------------------------------------
// sram_responder: wait-stated word SRAM responder with fault check, rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sram_responder #(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  sram_responder_if.slave bus
);

  localparam int unsigned C_AW        = $clog2(DEPTH);
  localparam logic [32:0] C_SPAN      = 33'(DEPTH) << 2;
  localparam logic [3:0]  C_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [3:0]   wstrb_q, wstrb_d;
  logic         instr_q, instr_d;
  logic         ready_q, ready_d;
  logic         fault_q, fault_d;
  logic [31:0]  rdata_q, rdata_d;

  logic [31:0]  mem_q [DEPTH];

  logic [31:0]     w_in_off, w_cap_off;
  logic            w_in_fault, w_cap_fault;
  logic [C_AW-1:0] w_in_idx, w_cap_idx;
  logic            w_enter_resp;
  logic [C_AW-1:0] w_resp_idx;
  logic            w_resp_fault;
  logic            w_commit;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
  assign w_in_off    = bus.mem_addr - BASE_ADDR;
  assign w_cap_off   = addr_q - BASE_ADDR;
  assign w_in_fault  = ({1'b0, w_in_off} >= C_SPAN) || (bus.mem_instr && (bus.mem_wstrb != 4'd0));
  assign w_cap_fault = ({1'b0, w_cap_off} >= C_SPAN) || (instr_q && (wstrb_q != 4'd0));
  assign w_in_idx    = w_in_off[C_AW+1:2];
  assign w_cap_idx   = w_cap_off[C_AW+1:2];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    instr_d      = instr_q;
    w_enter_resp = 1'b0;
    w_resp_idx   = w_cap_idx;
    w_resp_fault = w_cap_fault;

    case (state_q)
      S_IDLE: begin
        if (bus.mem_valid) begin
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          wstrb_d = bus.mem_wstrb;
          instr_d = bus.mem_instr;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = C_WAIT_INIT;
          end else begin
            // Zero wait states: the response is formed straight from the bus inputs.
            state_d      = S_RESP;
            w_enter_resp = 1'b1;
            w_resp_idx   = w_in_idx;
            w_resp_fault = w_in_fault;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered response: ready/fault/rdata are loaded on the edge entering RESP.
  assign ready_d = w_enter_resp;
  assign fault_d = w_enter_resp && w_resp_fault;
  assign rdata_d = (w_enter_resp && !w_resp_fault) ? mem_q[w_resp_idx] : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      instr_q <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      instr_q <= instr_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  // Write lands on the edge that ends RESP, after the pre-write word was returned.
  assign w_commit = (state_q == S_RESP) && (wstrb_q != 4'd0) && !w_cap_fault;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem_q[w_cap_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_fault = fault_q;
  assign bus.mem_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_responder.sv
// ------------------------------------------------------------------
// tb_sram_responder: randomized model-checked bench for sram_responder, rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_sram_responder;

  logic        clk;
  logic        rst;
  logic [1:0]  sel;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rdy;
  logic        flt;
  logic [31:0] rdat;

  int total = 0;
  int bad   = 0;

  int unsigned P_WS    [3] = '{2, 0, 3};
  int unsigned P_DEPTH [3] = '{4096, 16, 64};
  logic [31:0] P_BASE  [3] = '{32'h1000, 32'h0, 32'h0};

  logic [31:0] mdl [int];

  sram_responder_if if0 ();
  sram_responder_if if1 ();
  sram_responder_if if2 ();

  assign if0.mem_valid = valid && (sel == 2'd0);
  assign if1.mem_valid = valid && (sel == 2'd1);
  assign if2.mem_valid = valid && (sel == 2'd2);
  assign if0.mem_instr = instr;
  assign if1.mem_instr = instr;
  assign if2.mem_instr = instr;
  assign if0.mem_addr  = addr;
  assign if1.mem_addr  = addr;
  assign if2.mem_addr  = addr;
  assign if0.mem_wdata = wdata;
  assign if1.mem_wdata = wdata;
  assign if2.mem_wdata = wdata;
  assign if0.mem_wstrb = wstrb;
  assign if1.mem_wstrb = wstrb;
  assign if2.mem_wstrb = wstrb;

  always_comb begin
    rdy  = if0.mem_ready;
    flt  = if0.mem_fault;
    rdat = if0.mem_rdata;
    if (sel == 2'd1) begin
      rdy = if1.mem_ready; flt = if1.mem_fault; rdat = if1.mem_rdata;
    end else if (sel == 2'd2) begin
      rdy = if2.mem_ready; flt = if2.mem_fault; rdat = if2.mem_rdata;
    end
  end

  sram_responder #(.DEPTH(4096), .WAIT_STATES(2), .BASE_ADDR(32'h1000)) u_d0 (.clk(clk), .rst(rst), .bus(if0));
  sram_responder #(.DEPTH(16),   .WAIT_STATES(0), .BASE_ADDR(32'h0))    u_d1 (.clk(clk), .rst(rst), .bus(if1));
  sram_responder #(.DEPTH(64),   .WAIT_STATES(3), .BASE_ADDR(32'h0))    u_d2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int key_of(input int s, input logic [31:0] a);
    logic [31:0] off;
    off = a - P_BASE[s];
    return s * 8192 + int'(off >> 2);
  endfunction

  function automatic logic model_fault(input int s, input logic [31:0] a, input logic [3:0] st, input logic ins);
    logic [31:0] off;
    off = a - P_BASE[s];
    return ({1'b0, off} >= (33'(P_DEPTH[s]) * 33'd4)) || (ins && (st != 4'd0));
  endfunction

  // One complete transaction, checked against the reference model; returns observed rdata.
  task automatic do_txn(input int s, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st, input logic ins, input string tag,
                        output logic [31:0] rd);
    logic        efault;
    logic [31:0] erd;
    logic [31:0] t;
    int          k;
    int          n;
    logic        got;
    efault = model_fault(s, a, st, ins);
    k      = key_of(s, a);
    erd    = 32'd0;
    if (!efault) erd = mdl.exists(k) ? mdl[k] : 32'hxxxxxxxx;
    @(negedge clk);
    sel = 2'(s); valid = 1'b1; addr = a; wdata = d; wstrb = st; instr = ins;
    @(posedge clk);
    n = 0; got = 1'b0; rd = 32'd0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) valid = 1'b0;
      if (rdy) begin
        got = 1'b1;
        rd  = rdat;
      end
    end
    chk({tag, "_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      chk({tag, "_lat"}, n, P_WS[s] + 1);
      chk({tag, "_flt"}, {31'd0, flt}, {31'd0, efault});
      chk({tag, "_rd"}, rd, erd);
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, rdy}, 32'd0);
    end
    if (!efault && st != 4'd0) begin
      t = mdl.exists(k) ? mdl[k] : 32'd0;
      for (int b = 0; b < 4; b++) if (st[b]) t[8*b +: 8] = d[8*b +: 8];
      mdl[k] = t;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          cyc;
    int          last;
    int          kk;
    int          extra;
    logic [31:0] a;
    logic [3:0]  st;
    logic        ins;
    int          s;

    rst = 1'b1; sel = 2'd0; valid = 1'b0; instr = 1'b0;
    addr = 32'd0; wdata = 32'd0; wstrb = 4'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      #1;
      chk("rst_ready", {31'd0, rdy}, 32'd0);
      chk("rst_fault", {31'd0, flt}, 32'd0);
      chk("rst_rdata", rdat, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 8; w++)
        do_txn(i, P_BASE[i] + 32'(w * 4), $urandom, 4'hF, 1'b0, "init", rd);
    do_txn(0, 32'h4FFC, $urandom, 4'hF, 1'b0, "init_top", rd);

    do_txn(0, 32'h1010, 32'hDEADBEEF, 4'hF, 1'b0, "pre_dead", rd);
    do_txn(0, 32'h1010, 32'd0, 4'h0, 1'b0, "rd_dead", rd);
    chk("rd_dead_const", rd, 32'hDEADBEEF);
    do_txn(0, 32'h1010, 32'h11223344, 4'hF, 1'b0, "pre_byte", rd);
    do_txn(0, 32'h1010, 32'hAABBCCDD, 4'b0101, 1'b0, "byte_wr", rd);
    chk("byte_wr_old", rd, 32'h11223344);
    do_txn(0, 32'h1013, 32'd0, 4'h0, 1'b0, "byte_rd", rd);
    chk("byte_rd_const", rd, 32'h11BB33DD);

    do_txn(0, 32'h5000, 32'd0, 4'h0, 1'b0, "flt_hi", rd);
    do_txn(0, 32'h4FFC, 32'd0, 4'h0, 1'b0, "edge_hi", rd);
    do_txn(0, 32'h0FFC, 32'd0, 4'h0, 1'b0, "flt_lo", rd);
    do_txn(0, 32'h1000, 32'hCAFEF00D, 4'hF, 1'b1, "flt_iw", rd);
    do_txn(0, 32'h1000, 32'd0, 4'h0, 1'b1, "w0_kept", rd);

    // Back-to-back fetches with valid held high, address advanced on each ready.
    @(negedge clk);
    sel = 2'd1; valid = 1'b1; instr = 1'b1; wstrb = 4'd0; addr = 32'd0;
    cyc = 0; last = 0; kk = 0;
    while (cyc < 40 && kk < 3) begin
      @(negedge clk);
      cyc++;
      if (rdy) begin
        chk("b2b_rd", rdat, mdl[key_of(1, 32'(kk * 4))]);
        chk("b2b_flt", {31'd0, flt}, 32'd0);
        if (kk > 0) chk("b2b_gap", cyc - last, 2);
        last = cyc;
        kk++;
        if (kk == 3) valid = 1'b0;
        else addr = 32'(kk * 4);
      end
    end
    chk("b2b_count", kk, 3);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy) extra++;
    end
    chk("b2b_extra", extra, 0);

    do_txn(2, 32'h10, 32'h0BADF00D, 4'hF, 1'b0, "pre_rst", rd);
    @(negedge clk);
    sel = 2'd2; valid = 1'b1; addr = 32'h10; wdata = 32'h55AA55AA; wstrb = 4'hF; instr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy) extra++;
    end
    chk("rst_abort_ready", extra, 0);
    do_txn(2, 32'h10, 32'd0, 4'h0, 1'b0, "rst_abort_rd", rd);
    chk("rst_abort_const", rd, 32'h0BADF00D);

    for (int i = 0; i < 60; i++) begin
      s  = int'($urandom_range(0, 2));
      a  = P_BASE[s] + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        a = ($urandom_range(0, 1) == 0) ? (P_BASE[s] + P_DEPTH[s] * 4 + 32'($urandom_range(0, 255)))
                                        : (P_BASE[s] - 32'd4);
      st  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      ins = ($urandom_range(0, 3) == 0);
      do_txn(s, a, $urandom, st, ins, "rand", rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
